cmd_link_rcv: RTL and testbench

CMD_LINK_RCV -- requirements
Module: cmd_link_rcv

---
 rtl/quad_cmd_pkg.sv | 21 ++
 rtl/cmd_link_rcv_if.sv | 22 ++
 rtl/uart_byte.sv | 101 ++++++++++
 rtl/cmd_link_rcv.sv | 92 +++++++++
 tb/tb_cmd_link_rcv.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_cmd_pkg.sv
// rtl/quad_cmd_pkg.sv - opcodes, response codes and packet FSM states for the command link
package quad_cmd_pkg;

  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK   = 8'hA5;
  localparam logic [7:0] CAL_DONE  = 8'h5A;

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } pkt_state_t;

endpackage

// File: rtl/cmd_link_rcv_if.sv
// rtl/cmd_link_rcv_if.sv - serial lines, decoded packet and response handshake of the command link
interface cmd_link_rcv_if;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport slave (
    input  RX, clr_cmd_rdy, resp, send_resp,
    output TX, cmd, data, cmd_rdy, resp_sent
  );

  modport master (
    output RX, clr_cmd_rdy, resp, send_resp,
    input  TX, cmd, data, cmd_rdy, resp_sent
  );
endinterface

// File: rtl/uart_byte.sv
// rtl/uart_byte.sv - 8N1 byte receiver and transmitter sharing one bit-period setting
module uart_byte #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_rdy,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_start,
  output logic       o_tx_done
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

  logic             r_rx_s1, r_rx_s2, r_rx_busy, r_rx_rdy;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [3:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;

  logic             r_tx_busy, r_tx_done;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [9:0]       r_tx_shift;

  // Bit index 0 is the start sample, 1..8 data (LSB first), 9 the stop sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1  <= i_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= HALF_M1;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt <= FULL_M1;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_busy <= 1'b0;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          if (r_rx_s2) r_rx_rdy <= 1'b1;
        end else begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else begin
      r_tx_done <= 1'b0;
      if (!r_tx_busy) begin
        if (i_tx_start) begin
          r_tx_busy  <= 1'b1;
          r_tx_shift <= {1'b1, i_tx_byte, 1'b0};
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
        end
      end else if (r_tx_cnt != FULL_M1) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end else begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end else begin
          r_tx_bit   <= r_tx_bit + 4'd1;
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        end
      end
    end
  end

  assign o_tx      = r_tx_busy ? r_tx_shift[0] : 1'b1;
  assign o_tx_done = r_tx_done;
  assign o_rx_byte = r_rx_shift;
  assign o_rx_rdy  = r_rx_rdy;
endmodule

// File: rtl/cmd_link_rcv.sv
// rtl/cmd_link_rcv.sv - assembles 3-byte command packets from the serial link and sends response bytes
module cmd_link_rcv
  import quad_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int PKT_TMO  = 1_000_000
) (
  input logic           clk,
  input logic           rst,
  cmd_link_rcv_if.slave link
);
  localparam int TMO_W = $clog2(PKT_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PKT_TMO - 1);

  pkt_state_t       r_state, w_next;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [7:0]       w_rx_byte;
  logic             w_rx_rdy, w_tmo, w_pkt_done, w_new_pkt;
  logic [7:0]       r_cmd_tmp, r_data_hi, r_cmd;
  logic [15:0]      r_data;
  logic             r_cmd_rdy;

  uart_byte #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (link.RX),
    .o_tx       (link.TX),
    .o_rx_byte  (w_rx_byte),
    .o_rx_rdy   (w_rx_rdy),
    .i_tx_byte  (link.resp),
    .i_tx_start (link.send_resp),
    .o_tx_done  (link.resp_sent)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_CMD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pkt_done = 1'b0;
    w_new_pkt  = 1'b0;
    w_tmo      = (r_state != WAIT_CMD) && (r_tmo_cnt == TMO_LAST);
    case (r_state)
      WAIT_CMD: if (w_rx_rdy) begin
        w_next    = WAIT_HI;
        w_new_pkt = 1'b1;
      end
      WAIT_HI: begin
        if (w_rx_rdy)   w_next = WAIT_LO;
        else if (w_tmo) w_next = WAIT_CMD;
      end
      WAIT_LO: begin
        if (w_rx_rdy) begin
          w_next     = WAIT_CMD;
          w_pkt_done = 1'b1;
        end else if (w_tmo) begin
          w_next = WAIT_CMD;
        end
      end
      default: w_next = WAIT_CMD;
    endcase
  end

  // Idle counter restarts on every received byte; a completing packet beats a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_cmd_tmp <= '0;
      r_data_hi <= '0;
      r_cmd     <= '0;
      r_data    <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (r_state == WAIT_CMD || w_rx_rdy) r_tmo_cnt <= '0;
      else                                 r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_new_pkt) r_cmd_tmp <= w_rx_byte;
      if (r_state == WAIT_HI && w_rx_rdy) r_data_hi <= w_rx_byte;
      if (w_pkt_done) begin
        r_cmd  <= r_cmd_tmp;
        r_data <= {r_data_hi, w_rx_byte};
      end
      if (w_pkt_done)                           r_cmd_rdy <= 1'b1;
      else if (link.clr_cmd_rdy || w_new_pkt)   r_cmd_rdy <= 1'b0;
    end
  end

  assign link.cmd     = r_cmd;
  assign link.data    = r_data;
  assign link.cmd_rdy = r_cmd_rdy;
endmodule

// File: tb/tb_cmd_link_rcv.sv
// tb/tb_cmd_link_rcv.sv - scoreboard bench for cmd_link_rcv with a packet/frame reference model
module tb_cmd_link_rcv;
  import quad_cmd_pkg::*;

  localparam int BD  = 16;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_link_rcv_if link();

  cmd_link_rcv #(.BAUD_DIV(BD), .PKT_TMO(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } pkt_t;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  pkt_t   rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int     n_acc = 0, n_resp_sent = 0, n_tx_frames = 0, n_rdy_rise = 0;

  int         m_cnt = 0;
  logic [7:0] m_cmd = 8'h00, m_hi = 8'h00;
  longint     m_last = 0;
  longint     tx_free = 0;

  logic       prev_rdy = 1'b0;
  pkt_t       mon_e;
  logic [9:0] tx_f;
  int         tx_bad;

  logic [7:0] ops [7] = '{SET_PTCH, SET_ROLL, SET_YAW, SET_THRST, CALIBRATE, EMER_LAND, MTRS_OFF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit, input int nbits);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      link.RX = f[i];
      repeat (BD) @(negedge clk);
    end
    link.RX = 1'b1;
  endtask

  // Model: a good byte ends about 10 bit times from now; a gap beyond TMO drops a partial packet.
  task automatic host_byte(input logic [7:0] b, input logic stop_ok);
    longint t_end;
    if (stop_ok) begin
      t_end = cyc + 10 * BD;
      if (m_cnt > 0 && t_end - m_last > TMO) m_cnt = 0;
      m_last = t_end;
      case (m_cnt)
        0: begin m_cmd = b; m_cnt = 1; end
        1: begin m_hi = b; m_cnt = 2; end
        default: begin rx_exp_q.push_back({m_cmd, m_hi, b}); m_cnt = 0; end
      endcase
    end
    uart_send(b, stop_ok, 10);
    if (!stop_ok) repeat (2 * BD) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [15:0] d, input int gap);
    host_byte(c, 1'b1);
    repeat (gap) @(negedge clk);
    host_byte(d[15:8], 1'b1);
    repeat (gap) @(negedge clk);
    host_byte(d[7:0], 1'b1);
  endtask

  task automatic pulse_clr();
    link.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    link.clr_cmd_rdy = 1'b0;
  endtask

  task automatic req_resp(input logic [7:0] b);
    if (cyc >= tx_free) begin
      tx_exp_q.push_back(b);
      tx_free = cyc + 200;
      n_acc++;
    end
    link.resp      = b;
    link.send_resp = 1'b1;
    @(negedge clk);
    link.send_resp = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && link.cmd_rdy && !prev_rdy) begin
      n_rdy_rise++;
      if (rx_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cmd_rdy_unexpected actual cmd=%h data=%h required no packet", link.cmd, link.data);
      end else begin
        mon_e = rx_exp_q.pop_front();
        check("pkt_cmd", {24'h0, link.cmd}, {24'h0, mon_e.c});
        check("pkt_data", {16'h0, link.data}, {16'h0, mon_e.d});
      end
    end
    if (!rst && link.resp_sent) n_resp_sent++;
    prev_rdy = link.cmd_rdy;
  end

  // Each frame is checked cycle by cycle against {stop, byte, start}, then the done pulse timing.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && link.TX === 1'b0) begin
        tx_bad = 0;
        if (tx_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected_frame actual start bit required idle line");
          tx_f = 10'h000;
        end else begin
          tx_f = {1'b1, tx_exp_q.pop_front(), 1'b0};
        end
        for (int k = 0; k < 10 * BD; k++) begin
          if (k > 0) @(negedge clk);
          if (link.TX !== tx_f[k / BD]) tx_bad++;
          if (link.resp_sent !== 1'b0) tx_bad++;
        end
        @(negedge clk);
        check("tx_frame_bits", tx_bad, 0);
        check("resp_sent_at_stop_end", {30'h0, link.resp_sent, link.TX}, 32'h3);
        @(negedge clk);
        check("resp_sent_one_cycle", {31'h0, link.resp_sent}, 32'h0);
        n_tx_frames++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=time_limit required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx"}, {31'h0, link.TX}, 32'h1);
    check({tag, "_cmd"}, {24'h0, link.cmd}, 32'h0);
    check({tag, "_data"}, {16'h0, link.data}, 32'h0);
    check({tag, "_cmd_rdy"}, {31'h0, link.cmd_rdy}, 32'h0);
    check({tag, "_resp_sent"}, {31'h0, link.resp_sent}, 32'h0);
  endtask

  initial begin
    int         rise0;
    logic [7:0] rc;
    logic [15:0] rd;
    logic       bad_first;
    int         gap, txw;
    link.RX = 1'b1;
    link.clr_cmd_rdy = 1'b0;
    link.resp = 8'h00;
    link.send_resp = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    send_pkt(SET_THRST, 16'h1234, 0);
    repeat (100) @(negedge clk);
    check("rdy_held", {31'h0, link.cmd_rdy}, 32'h1);
    pulse_clr();
    check("rdy_cleared", {31'h0, link.cmd_rdy}, 32'h0);

    host_byte(SET_ROLL, 1'b1);
    host_byte(8'hBE, 1'b1);
    repeat (2500) @(negedge clk);
    check("tmo_no_rdy", {31'h0, link.cmd_rdy}, 32'h0);
    send_pkt(SET_YAW, 16'h8DA0, 0);
    repeat (20) @(negedge clk);
    pulse_clr();

    host_byte(SET_PTCH, 1'b0);
    send_pkt(SET_PTCH, 16'h1F4B, 0);
    repeat (20) @(negedge clk);
    pulse_clr();

    req_resp(POS_ACK);
    repeat (19) @(negedge clk);
    req_resp(8'h77);
    repeat (250) @(negedge clk);
    check("tx_one_frame", n_tx_frames, 1);
    check("tx_one_resp_sent", n_resp_sent, 1);

    rise0 = n_rdy_rise;
    link.clr_cmd_rdy = 1'b1;
    send_pkt(MTRS_OFF, 16'hC3E1, 0);
    repeat (5) @(negedge clk);
    link.clr_cmd_rdy = 1'b0;
    check("coincident_set_wins", n_rdy_rise - rise0, 1);

    host_byte(CALIBRATE, 1'b1);
    uart_send(8'h00, 1'b1, 5);
    rst = 1'b1;
    m_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rise0 = n_rdy_rise;
    send_pkt(CALIBRATE, 16'h0000, 0);
    repeat (20) @(negedge clk);
    check("post_rst_pkt", n_rdy_rise - rise0, 1);
    pulse_clr();

    fork
      send_pkt(EMER_LAND, 16'h0000, 0);
      begin
        repeat (37) @(negedge clk);
        req_resp(CAL_DONE);
      end
    join
    repeat (200) @(negedge clk);
    pulse_clr();

    for (int it = 0; it < 12; it++) begin
      rc = ops[$urandom_range(0, 6)];
      rd = 16'($urandom);
      bad_first = ($urandom_range(0, 3) == 0);
      gap = $urandom_range(0, 40);
      txw = $urandom_range(0, 300);
      fork
        begin
          if (bad_first) host_byte(8'($urandom), 1'b0);
          send_pkt(rc, rd, gap);
        end
        begin
          repeat (txw) @(negedge clk);
          req_resp(8'($urandom));
        end
      join
      repeat (20) @(negedge clk);
      pulse_clr();
    end

    repeat (400) @(negedge clk);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("resp_sent_total", n_resp_sent, n_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
